// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared constants for the RISC-V pipeline slice: datapath width, width of
//   the opaque EX/MEM/WB control bundle, register-index width and the index
//   of the hardwired-zero register x0.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] X0 = '0;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector
//   Combinational load-use hazard detection. A hazard exists when the
//   instruction in EX is a valid load writing a non-zero register and the
//   valid instruction in ID reads that register through rs1 or rs2. The
//   forwarding unit cannot cover this case because the load data only
//   appears after MEM.
// Ports:
//   valid_ex, mem_read_ex, rd_ex    - current EX-stage registers
//   valid_id, use_rs*_id, rs*_id    - decoded ID-stage operand usage
//   hz                              - hazard flag
module load_use_detector
    import riscv_pkg::*;
(
    input  logic             valid_ex,
    input  logic             mem_read_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             valid_id,
    input  logic             use_rs1_id,
    input  logic [REG_W-1:0] rs1_id,
    input  logic             use_rs2_id,
    input  logic [REG_W-1:0] rs2_id,
    output logic             hz
);

    logic hit1, hit2;

    always_comb begin
        hit1 = use_rs1_id && (rs1_id == rd_ex);
        hit2 = use_rs2_id && (rs2_id == rd_ex);
        hz   = valid_ex && mem_read_ex && (rd_ex != X0) && valid_id && (hit1 || hit2);
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with load-use interlock.
//   Per-cycle priority: mem_busy (freeze everything) > flush (bubble) >
//   load-use hazard (bubble + hold frontend + count) > normal load.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   *_id                            - decoded instruction from ID
//   flush                           - taken branch/jump from EX
//   mem_busy                        - data memory stall, freezes the stage
//   stall_id                        - combinational hold for PC and IF/ID
//   *_ex                            - registered EX-stage fields
//   load_use_cnt                    - saturating count of load-use bubbles
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int CTRL_W = riscv_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_id,
    input  logic [REG_W-1:0]  rs1_id,
    input  logic [REG_W-1:0]  rs2_id,
    input  logic [REG_W-1:0]  rd_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic              reg_write_id,
    input  logic              mem_read_id,
    input  logic [XLEN-1:0]   rdata1_id,
    input  logic [XLEN-1:0]   rdata2_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              stall_id,
    output logic              valid_ex,
    output logic              mem_read_ex,
    output logic [REG_W-1:0]  rs1_ex,
    output logic [REG_W-1:0]  rs2_ex,
    output logic [REG_W-1:0]  rd_ex,
    output logic [XLEN-1:0]   rdata1_ex,
    output logic [XLEN-1:0]   rdata2_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [CNT_W-1:0]  load_use_cnt
);

    logic hz;
    logic do_bubble;   // load a bubble into EX
    logic do_load;     // load the ID instruction into EX
    logic do_count;    // bubble caused by a load-use hazard

    load_use_detector u_hz (
        .valid_ex    (valid_ex),
        .mem_read_ex (mem_read_ex),
        .rd_ex       (rd_ex),
        .valid_id    (valid_id),
        .use_rs1_id  (use_rs1_id),
        .rs1_id      (rs1_id),
        .use_rs2_id  (use_rs2_id),
        .rs2_id      (rs2_id),
        .hz          (hz)
    );

    always_comb begin
        // A flush kills the ID instruction anyway, so no need to hold IF/ID.
        stall_id  = mem_busy || (!flush && hz);
        do_bubble = !mem_busy && (flush || hz || !valid_id);
        do_load   = !mem_busy && !flush && !hz && valid_id;
        do_count  = !mem_busy && !flush && hz;
    end

    // Control fields: cleared on a bubble, held on mem_busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex    <= 1'b0;
            mem_read_ex <= 1'b0;
            rs1_ex      <= X0;
            rs2_ex      <= X0;
            rd_ex       <= X0;
            ctrl_ex     <= '0;
        end else if (do_bubble) begin
            valid_ex    <= 1'b0;
            mem_read_ex <= 1'b0;
            rs1_ex      <= X0;
            rs2_ex      <= X0;
            rd_ex       <= X0;
            ctrl_ex     <= '0;
        end else if (do_load) begin
            valid_ex    <= 1'b1;
            mem_read_ex <= mem_read_id;
            // Unused operands/destination are squashed to x0 so the
            // forwarding unit and this detector never match on them.
            rs1_ex      <= use_rs1_id   ? rs1_id : X0;
            rs2_ex      <= use_rs2_id   ? rs2_id : X0;
            rd_ex       <= reg_write_id ? rd_id  : X0;
            ctrl_ex     <= ctrl_id;
        end
    end

    // Data fields are don't-care in a bubble, so they only move on a real load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1_ex <= '0;
            rdata2_ex <= '0;
            imm_ex    <= '0;
            pc_ex     <= '0;
        end else if (do_load) begin
            rdata1_ex <= rdata1_id;
            rdata2_ex <= rdata2_id;
            imm_ex    <= imm_id;
            pc_ex     <= pc_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_use_cnt <= '0;
        else if (do_count && (load_use_cnt != {CNT_W{1'b1}}))
            load_use_cnt <= load_use_cnt + 1'b1;
    end

endmodule
